// File: rtl/byte_serializer_pkg.sv
// Shared constants and FSM state encoding for the byte serializer.
package byte_serializer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/byte_hold_reg.sv
// Single-entry holding register that buffers the next byte while the shifter is busy.
module byte_hold_reg
    import byte_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] hold,
    output logic             hold_full
);

    // Load takes priority; load and clear are never requested together by the parent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (load) begin
            hold      <= din;
            hold_full <= 1'b1;
        end else if (clear) begin
            hold_full <= 1'b0;
        end
    end

endmodule

// File: rtl/byte_serializer.sv
// Parallel-to-serial converter, MSB first, with a one-byte holding buffer for gapless streaming.
module byte_serializer
    import byte_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   shreg_q;
    logic [WIDTH-1:0]   shreg_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [WIDTH-1:0]   hold;
    logic               hold_full;
    logic               hold_full_d;
    logic               hold_load;
    logic               hold_clear;
    logic               accept;

    // Ready comes straight from the hold flag register, never from din_valid.
    assign din_ready = ~hold_full;
    assign accept    = din_valid & ~hold_full;

    byte_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .reset     (reset),
        .load      (hold_load),
        .clear     (hold_clear),
        .din       (din),
        .hold      (hold),
        .hold_full (hold_full)
    );

    // Next-state, shifter and hold-buffer control.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        hold_load  = 1'b0;
        hold_clear = 1'b0;

        case (state_q)
            IDLE: begin
                if (hold_full) begin
                    shreg_d    = hold;
                    cnt_d      = '0;
                    hold_clear = 1'b1;
                    state_d    = SHIFT;
                end else if (accept) begin
                    shreg_d = din;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                hold_load = accept;
                shreg_d   = shreg_q << 1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (hold_full) begin
                        // Chain straight into the buffered byte so no idle bit is inserted.
                        shreg_d    = hold;
                        hold_clear = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        hold_full_d = hold_load | (hold_full & ~hold_clear);
    end

    // State register plus outputs registered from their next-cycle values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            sout_last  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            sout       <= (state_d == SHIFT) & shreg_d[WIDTH-1];
            sout_valid <= (state_d == SHIFT);
            sout_last  <= (state_d == SHIFT) & (cnt_d == LAST_CNT);
            busy       <= (state_d == SHIFT) | hold_full_d;
        end
    end

endmodule

// File: tb/tb_byte_serializer.sv
// Directed and randomized checks of byte_serializer against a byte-queue reference model.
module tb_byte_serializer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         sout;
    logic         sout_valid;
    logic         sout_last;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    // Reference model state for the random phase: bytes accepted but not yet fully emitted.
    logic [W-1:0] q[$];
    logic [W-1:0] cur;
    int           nbits;

    byte_serializer #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_last  (sout_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(sout_valid), 32'd0);
        chk({tag, "_sout"},  32'(sout),       32'd0);
        chk({tag, "_last"},  32'(sout_last),  32'd0);
        chk({tag, "_busy"},  32'(busy),       32'd0);
        chk({tag, "_ready"}, 32'(din_ready),  32'd1);
    endtask

    task automatic chk_bit(input string tag, input logic b, input logic last);
        chk({tag, "_valid"}, 32'(sout_valid), 32'd1);
        chk({tag, "_sout"},  32'(sout),       32'(b));
        chk({tag, "_last"},  32'(sout_last),  32'(last));
        chk({tag, "_busy"},  32'(busy),       32'd1);
    endtask

    // Random-phase observer: rebuilds bytes from the serial stream and retires them from the queue.
    task automatic observe();
        chk("rnd_busy", 32'(busy), 32'(q.size() != 0));
        if (sout_valid) begin
            cur = {cur[W-2:0], sout};
            nbits++;
            if (sout_last) begin
                chk("rnd_len", 32'(nbits), 32'(W));
                chk("rnd_q_nonempty", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) chk("rnd_byte", 32'(cur), 32'(q.pop_front()));
                nbits = 0;
            end else begin
                chk("rnd_overrun", 32'(nbits < int'(W)), 32'd1);
            end
        end else begin
            chk("rnd_gap", 32'(nbits), 32'd0);
            chk("rnd_idle_sout", 32'(sout), 32'd0);
        end
    endtask

    initial begin
        logic [7:0]  v8;
        logic [15:0] v16;
        logic [23:0] v24;
        logic        exp_rdy;
        logic        acc;

        reset     = 1'b1;
        din       = '0;
        din_valid = 1'b0;

        // Reset held three cycles, then released with no traffic.
        repeat (3) begin
            tick();
            chk_idle("reset_hold");
        end
        reset = 1'b0;
        repeat (3) begin
            tick();
            chk_idle("post_reset");
        end

        // Single byte from idle.
        din = 8'hA5; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        v8 = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            chk_bit("a5", v8[7-i], i == 7);
            tick();
        end
        chk_idle("a5_done");

        // Two bytes back to back, no gap.
        din = 8'h3C; din_valid = 1'b1;
        tick();
        din = 8'hC3;
        v16 = 16'h3CC3;
        for (int i = 0; i < 16; i++) begin
            chk_bit("b2b", v16[15-i], (i == 7) || (i == 15));
            tick();
            if (i == 0) din_valid = 1'b0;
        end
        chk_idle("b2b_done");

        // Third byte offered while the hold buffer is full.
        din = 8'h12; din_valid = 1'b1;
        tick();
        din = 8'h34;
        v24 = 24'h1234FF;
        for (int k = 0; k < 24; k++) begin
            exp_rdy = (k == 0) || (k == 8) || (k >= 16);
            chk_bit("ff", v24[23-k], (k == 7) || (k == 15) || (k == 23));
            chk("ff_ready", 32'(din_ready), 32'(exp_rdy));
            tick();
            if (k == 0) din = 8'hFF;
            if (k == 8) din_valid = 1'b0;
        end
        chk_idle("ff_done");

        // Reset mid-byte with a byte held.
        din = 8'h81; din_valid = 1'b1;
        tick();
        din = 8'h7E;
        v8 = 8'h81;
        for (int k = 0; k < 3; k++) begin
            chk_bit("rst81", v8[7-k], 1'b0);
            tick();
            if (k == 0) din_valid = 1'b0;
        end
        chk_bit("rst81_b3", v8[4], 1'b0);
        chk("rst81_held", 32'(din_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk_idle("rst_async");
        tick();
        chk_idle("rst_next");
        reset = 1'b0;
        repeat (12) begin
            tick();
            chk_idle("rst_after");
        end

        // Byte offered while not ready and withdrawn is never emitted.
        din = 8'hAA; din_valid = 1'b1;
        tick();
        din = 8'h0F;
        v16 = 16'hAA0F;
        for (int k = 0; k < 16; k++) begin
            chk_bit("w55", v16[15-k], (k == 7) || (k == 15));
            if (k >= 1 && k <= 3) chk("w55_ready", 32'(din_ready), 32'd0);
            tick();
            if (k == 0) din = 8'h55;
            if (k == 3) din_valid = 1'b0;
        end
        repeat (10) begin
            chk_idle("w55_after");
            tick();
        end

        // Randomized traffic checked against the byte queue.
        cur   = '0;
        nbits = 0;
        for (int c = 0; c < 700; c++) begin
            if (!din_valid && c < 600 && $urandom_range(0, 2) != 0) begin
                din       = 8'($urandom);
                din_valid = 1'b1;
            end
            acc = din_valid && din_ready;
            tick();
            if (acc) begin
                q.push_back(din);
                din_valid = 1'b0;
            end
            observe();
        end
        chk("rnd_drained", 32'(q.size()), 32'd0);
        chk_idle("rnd_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
